// File: rtl/aer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aer_pkg
//  Description : Shared types and width helpers for the inbound AER receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package aer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK_HI  = 2'd1,
        WAIT_LO = 2'd2
    } aer_rx_state_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : aer_fifo
//  Description : First-word-fall-through FIFO with registered flags and count.
//  Revision    : 1.0 - initial release
// ============================================================================
module aer_fifo
    import aer_pkg::*;
#(
    parameter int M     = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [M-1:0]                  push_data,
    input  logic                          pop,
    output logic [M-1:0]                  head,
    output logic                          valid,
    output logic                          full,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [M-1:0]  mem_q [DEPTH];
    logic [M-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic          push_ok;
    logic          pop_ok;

    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && valid_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Flags are registered from the next count so no output depends on pop.
        valid_d = (count_d != '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = valid_q;
    assign full  = full_q;
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/aer_in.sv
`default_nettype none
// ============================================================================
//  Module      : aer_in
//  Description : Inbound AER 4-phase receiver: REQ synchronizer, ACK FSM, FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module aer_in
    import aer_pkg::*;
#(
    parameter int N           = 256,
    parameter int M           = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_HOLD    = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [M-1:0]                  AERIN_ADDR,
    input  logic                          AERIN_REQ,
    output logic                          AERIN_ACK,
    output logic                          AERIN_CTRL_VALID,
    output logic [M-1:0]                  AERIN_CTRL_ADDR,
    input  logic                          CTRL_AERIN_POP,
    output logic                          AERIN_CTRL_FULL,
    output logic [count_width(DEPTH)-1:0] AERIN_CTRL_COUNT
);

    localparam int HW = $clog2(ACK_HOLD + 1);

    if (((1 << M) < N) || (SYNC_STAGES < 2) || (ACK_HOLD < 1) || (DEPTH < 2) ||
        ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_params
        $error("aer_in: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    aer_rx_state_t          state_q, state_d;
    logic                   ack_q, ack_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   req_s;
    logic                   push;
    logic                   fifo_full;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], AERIN_REQ};
        state_d = state_q;
        ack_d   = ack_q;
        hold_d  = hold_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                // A full FIFO stalls the handshake by withholding ACK.
                if (req_s && !fifo_full) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    hold_d  = HW'(ACK_HOLD - 1);
                    state_d = ACK_HI;
                end
            end
            ACK_HI: begin
                if (hold_q == '0) begin
                    ack_d   = 1'b0;
                    state_d = WAIT_LO;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            WAIT_LO: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= '0;
            state_q <= IDLE;
            ack_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            ack_q   <= ack_d;
            hold_q  <= hold_d;
        end
    end

    aer_fifo #(
        .M     (M),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (AERIN_ADDR),
        .pop       (CTRL_AERIN_POP),
        .head      (AERIN_CTRL_ADDR),
        .valid     (AERIN_CTRL_VALID),
        .full      (fifo_full),
        .count     (AERIN_CTRL_COUNT)
    );

    assign AERIN_ACK       = ack_q;
    assign AERIN_CTRL_FULL = fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_aer_in.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aer_in
//  Description : Self-checking bench for aer_in: vector table, corner sequences, random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aer_in;

    localparam int M     = 8;
    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int H     = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic       req;
    logic       pop;
    logic       ack;
    logic       valid;
    logic       full;
    logic [7:0] head;
    logic [2:0] count;

    always #5 clk = ~clk;

    aer_in #(
        .N           (256),
        .M           (M),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (S),
        .ACK_HOLD    (H)
    ) dut (
        .CLK              (clk),
        .RST              (rst),
        .AERIN_ADDR       (addr),
        .AERIN_REQ        (req),
        .AERIN_ACK        (ack),
        .AERIN_CTRL_VALID (valid),
        .AERIN_CTRL_ADDR  (head),
        .CTRL_AERIN_POP   (pop),
        .AERIN_CTRL_FULL  (full),
        .AERIN_CTRL_COUNT (count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: REQ samples delayed by the synchronizer depth, a queue for the
    // FIFO, and the remaining ACK-high cycles of the current handshake.
    bit         req_hist[$];
    logic [7:0] m_fifo[$];
    int         m_ack_rem  = 0;
    bit         m_need_low = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_edge(input bit r_rst, input bit r_req,
                                       input logic [7:0] r_addr, input bit r_pop);
        bit seen;
        bit do_push;
        int sz;
        if (r_rst) begin
            req_hist.delete();
            m_fifo.delete();
            m_ack_rem  = 0;
            m_need_low = 0;
            return;
        end
        seen = 1'b0;
        req_hist.push_back(r_req);
        if (req_hist.size() > S) seen = req_hist.pop_front();
        sz      = m_fifo.size();
        do_push = 1'b0;
        if (m_ack_rem > 0) begin
            m_ack_rem--;
            if (m_ack_rem == 0) m_need_low = 1'b1;
        end else if (m_need_low) begin
            if (!seen) m_need_low = 1'b0;
        end else if (seen && sz < DEPTH) begin
            do_push   = 1'b1;
            m_ack_rem = H;
        end
        if (r_pop && sz > 0) void'(m_fifo.pop_front());
        if (do_push) m_fifo.push_back(r_addr);
    endfunction

    task automatic step(input bit r_rst, input bit r_req, input logic [7:0] r_addr, input bit r_pop);
        rst  = r_rst;
        req  = r_req;
        addr = r_addr;
        pop  = r_pop;
        @(posedge clk);
        model_edge(r_rst, r_req, r_addr, r_pop);
        #1;
        chk("model_ack", ack, (m_ack_rem > 0));
        chk("model_valid", valid, (m_fifo.size() > 0));
        chk("model_count", count, m_fifo.size());
        chk("model_full", full, (m_fifo.size() == DEPTH));
        if (m_fifo.size() > 0) chk("model_head", head, m_fifo[0]);
    endtask

    // Full handshake: hold REQ until ACK has risen and fallen, then release and let the FSM idle.
    task automatic xfer(input logic [7:0] a);
        bit seen_ack;
        seen_ack = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b1, a, 1'b0);
            if (ack) seen_ack = 1'b1;
            else if (seen_ack) break;
        end
        chk("xfer_handshake_done", (seen_ack && !ack), 1);
        repeat (S + 1) step(1'b0, 1'b0, a, 1'b0);
    endtask

    typedef struct {
        bit         rst;
        bit         req;
        logic [7:0] addr;
        bit         pop;
        int         ncyc;
        bit         e_ack;
        bit         e_valid;
        int         e_count;
        bit         chk_head;
        logic [7:0] e_head;
    } vec_t;

    vec_t tbl[19];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] got;
        bit         r_req;
        logic [7:0] r_addr;
        int         tx;
        int         hold;

        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0,  2, 1'b0, 1'b0, 0, 1'b1, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h5A, 1'b0,  1, 1'b0, 1'b0, 0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 8'h5A, 1'b0,  1, 1'b0, 1'b0, 0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 8'h5A, 1'b0,  1, 1'b1, 1'b1, 1, 1'b1, 8'h5A};
        tbl[4]  = '{1'b0, 1'b1, 8'h5A, 1'b0,  1, 1'b1, 1'b1, 1, 1'b1, 8'h5A};
        tbl[5]  = '{1'b0, 1'b1, 8'h5A, 1'b0,  1, 1'b0, 1'b1, 1, 1'b1, 8'h5A};
        tbl[6]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 20, 1'b0, 1'b1, 1, 1'b1, 8'h5A};
        tbl[7]  = '{1'b0, 1'b0, 8'h5A, 1'b0,  3, 1'b0, 1'b1, 1, 1'b1, 8'h5A};
        tbl[8]  = '{1'b0, 1'b1, 8'h3C, 1'b0,  2, 1'b0, 1'b1, 1, 1'b1, 8'h5A};
        tbl[9]  = '{1'b0, 1'b1, 8'h3C, 1'b0,  1, 1'b1, 1'b1, 2, 1'b1, 8'h5A};
        tbl[10] = '{1'b0, 1'b1, 8'h3C, 1'b1,  1, 1'b1, 1'b1, 1, 1'b1, 8'h3C};
        tbl[11] = '{1'b0, 1'b1, 8'h3C, 1'b0,  1, 1'b0, 1'b1, 1, 1'b1, 8'h3C};
        tbl[12] = '{1'b0, 1'b0, 8'h3C, 1'b1,  1, 1'b0, 1'b0, 0, 1'b0, 8'h00};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1,  2, 1'b0, 1'b0, 0, 1'b0, 8'h00};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0,  2, 1'b0, 1'b0, 0, 1'b0, 8'h00};
        tbl[15] = '{1'b0, 1'b1, 8'hA7, 1'b0,  3, 1'b1, 1'b1, 1, 1'b1, 8'hA7};
        tbl[16] = '{1'b0, 1'b0, 8'hA7, 1'b0,  1, 1'b1, 1'b1, 1, 1'b1, 8'hA7};
        tbl[17] = '{1'b0, 1'b0, 8'hA7, 1'b1,  1, 1'b0, 1'b0, 0, 1'b0, 8'h00};
        tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b0,  3, 1'b0, 1'b0, 0, 1'b0, 8'h00};

        for (int i = 0; i < 19; i++) begin
            repeat (tbl[i].ncyc) step(tbl[i].rst, tbl[i].req, tbl[i].addr, tbl[i].pop);
            chk($sformatf("row%0d_ack", i), ack, tbl[i].e_ack);
            chk($sformatf("row%0d_valid", i), valid, tbl[i].e_valid);
            chk($sformatf("row%0d_count", i), count, tbl[i].e_count);
            if (tbl[i].chk_head) chk($sformatf("row%0d_head", i), head, tbl[i].e_head);
        end

        // Backpressure: four events fill the FIFO, the fifth stalls until a pop.
        for (int i = 1; i <= 4; i++) xfer(8'(i));
        chk("bp_count_full", count, 4);
        chk("bp_full", full, 1);
        repeat (10) step(1'b0, 1'b1, 8'h05, 1'b0);
        chk("bp_stall_ack", ack, 0);
        step(1'b0, 1'b1, 8'h05, 1'b1);
        chk("bp_pop_count", count, 3);
        chk("bp_pop_no_ack", ack, 0);
        step(1'b0, 1'b1, 8'h05, 1'b0);
        chk("bp_late_ack", ack, 1);
        chk("bp_late_count", count, 4);
        xfer(8'h05);
        for (int i = 2; i <= 5; i++) begin
            chk("bp_drain_order", head, i);
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("bp_drained", valid, 0);

        // Wrap-around with push and pop on the same edge at COUNT=2.
        for (int i = 0; i < 10; i++) begin
            if (i < 2) begin
                xfer(8'h10 + 8'(i));
            end else begin
                step(1'b0, 1'b1, 8'h10 + 8'(i), 1'b0);
                step(1'b0, 1'b1, 8'h10 + 8'(i), 1'b0);
                got = head;
                step(1'b0, 1'b1, 8'h10 + 8'(i), 1'b1);
                chk("wrap_count_steady", count, 2);
                chk("wrap_popped", got, 8'h10 + 8'(i - 2));
                chk("wrap_ack", ack, 1);
                xfer(8'h10 + 8'(i));
            end
        end
        for (int i = 8; i < 10; i++) begin
            chk("wrap_tail", head, 8'h10 + 8'(i));
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end

        // Reset mid-handshake with COUNT=3 and REQ held through reset.
        xfer(8'hA1);
        xfer(8'hA2);
        xfer(8'hA3);
        step(1'b0, 1'b1, 8'hA4, 1'b0);
        step(1'b0, 1'b1, 8'hA4, 1'b0);
        step(1'b0, 1'b1, 8'hA4, 1'b1);
        chk("rst_pre_count", count, 3);
        step(1'b1, 1'b1, 8'hA4, 1'b0);
        chk("rst_ack", ack, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", valid, 0);
        step(1'b0, 1'b1, 8'hA4, 1'b0);
        step(1'b0, 1'b1, 8'hA4, 1'b0);
        chk("rst_no_early_push", count, 0);
        step(1'b0, 1'b1, 8'hA4, 1'b0);
        chk("rst_repush_count", count, 1);
        chk("rst_repush_head", head, 8'hA4);
        xfer(8'hA4);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic from a well-behaved transmitter with random pops and rare resets.
        r_req  = 1'b0;
        r_addr = 8'h00;
        tx     = 0;
        hold   = 0;
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 499) == 0), r_req, r_addr, ($urandom_range(0, 99) < 35));
            case (tx)
                0: if ($urandom_range(0, 3) == 0) begin
                       r_req  = 1'b1;
                       r_addr = 8'($urandom);
                       tx     = 1;
                   end
                1: if (ack) tx = 2;
                2: if (!ack) begin
                       hold = $urandom_range(0, 4);
                       tx   = 3;
                   end
                default: if (hold == 0) begin
                       r_req = 1'b0;
                       tx    = 0;
                   end else begin
                       hold--;
                   end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aer_in.md
# aer_in

Inbound AER receiver: the receiving end of the 4-phase REQ/ACK address-event link that the chip's AER transmitter drives. It synchronizes the asynchronous `AERIN_REQ`, captures `AERIN_ADDR`, and completes the handshake with a fixed-width ACK pulse. Captured addresses go into a small first-word-fall-through FIFO drained by the controller/scheduler. Backpressure is applied by withholding ACK while the FIFO is full.

## Interface
- `N`, 256, number of neurons
- `M`, 8, address width; must satisfy 2^M ≥ N
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `SYNC_STAGES`, 2, REQ synchronizer flops; ≥2
- `ACK_HOLD`, 2, cycles ACK is held high; ≥1
- `CLK`  in  1  single clock
- `RST`  in  1  synchronous, active-high reset
- `AERIN_ADDR`  in  M  event address; stable while REQ is high
- `AERIN_REQ`  in  1  asynchronous request
- `AERIN_ACK`  out  1  acknowledge (registered)
- `AERIN_CTRL_VALID`  out  1  FIFO non-empty
- `AERIN_CTRL_ADDR`  out  M  FIFO head; meaningful only when VALID
- `CTRL_AERIN_POP`  in  1  controller pops the head
- `AERIN_CTRL_FULL`  out  1  FIFO full
- `AERIN_CTRL_COUNT`  out  $clog2(DEPTH)+1  occupancy

## Operation
- Reset (synchronous, takes effect at the edge): ACK=0, FIFO flushed (COUNT=0, VALID=0, FULL=0, pointers=0), synchronizer cleared, FSM=IDLE. `AERIN_CTRL_ADDR` reads 0 after reset.
- `req_s` is the output of the `SYNC_STAGES` synchronizer. Only `req_s` is used by the FSM.
- FSM states:
  - IDLE: if `req_s` && !FULL, then push `AERIN_ADDR` (sampled directly from the pin), ACK<=1, load hold counter to `ACK_HOLD`-1, and go to ACK_HI. If `req_s` && FULL, stay in IDLE with ACK=0 (stall). The push happens once a pop frees a slot.
  - ACK_HI: count down. At 0: ACK<=0 and go to WAIT_LO.
  - WAIT_LO: stay until `req_s`==0, then go to IDLE. This guarantees one push per REQ pulse, even if REQ stays high long after ACK falls.
- FIFO: a push is accepted only when !FULL. A pop when empty is ignored.
  - Simultaneous push and pop with 0<COUNT<DEPTH: COUNT unchanged, head advances.
  - FULL is evaluated on the registered COUNT. A pop in the same cycle does not enable a push from IDLE; that push waits one cycle.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH.
- The head entry and its VALID are visible the cycle after the push edge.
- REQ held high across reset is treated as a new event after reset.

## Timing
- REQ first sampled high at edge t → ACK=1 and the push happen at edge t+SYNC_STAGES. VALID is visible after that same edge.
- ACK high for exactly `ACK_HOLD` cycles, then low.
- REQ low sampled at edge u while in WAIT_LO → IDLE after edge u+SYNC_STAGES. The next REQ is accepted at the earliest one cycle later.
- Pop at edge p → new head/VALID/COUNT after edge p. There is no combinational path from POP to any output.
- All outputs are registered except `AERIN_CTRL_ADDR`, which is a mux from a registered pointer and the storage.

## Structure
- Shared package `aer_pkg`: `aer_rx_state_t` enum (IDLE, ACK_HI, WAIT_LO), localparam helpers for pointer/count widths.
- Sub-module `aer_fifo` (parameters M, DEPTH): push/pop/full/empty/count, FWFT head. The FSM and synchronizer stay in `aer_in`.

## Test plan
- Single event, defaults: ADDR=0x5A, REQ rises at edge 10 → ACK high at edges 12–13 (low after edge 14), VALID=1 and AERIN_CTRL_ADDR=0x5A after edge 12. Hold REQ until ACK falls, then drop it; POP → VALID=0, COUNT=0.
- Long REQ: keep REQ high 20 cycles after ACK falls → exactly one push (COUNT=1). No second ACK until REQ goes low, then high again.
- Backpressure: send 5 events without popping, DEPTH=4 → COUNT=4, FULL=1. The 5th REQ gets no ACK. POP → 5th pushed one cycle later. Drain order matches send order 0x01..0x05.
- Wrap-around: 10 events interleaved with pops (push/pop in the same cycle at COUNT=2) → COUNT stays 2 across that edge. All 10 addresses are read in order with no loss or duplication.
- Pop when empty: POP pulsed at COUNT=0 → COUNT stays 0, pointers unchanged. The next event is read correctly.
- Reset mid-handshake: RST asserted during ACK_HI with COUNT=3 → after the edge ACK=0, COUNT=0, VALID=0. REQ still high → a new push occurs SYNC_STAGES edges after reset is released.
